lomo_frame_receiver: RTL and testbench

//  Downstream consumer of the LOMO imitator serial triple (MK marker, CLK bit clock, SRL data).

---
 rtl/lomo_pkg.sv | 18 +
 rtl/lomo_edge_sync.sv | 42 ++++
 rtl/lomo_frame_receiver.sv | 225 ++++++++++++++++++++++
 tb/tb_lomo_frame_receiver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lomo_pkg.sv
// lomo_pkg
//   Constants and types shared by both ends of the LOMO serial link (imitator
//   frame former and frame receiver), so that word size, frame length and
//   receiver state encoding agree on both sides.
//   No ports; import with "import lomo_pkg::*;".
package lomo_pkg;

    localparam int LOMO_WORD_BITS   = 12;
    localparam int LOMO_FRAME_WORDS = 32;
    localparam int LOMO_TIMEOUT_CYC = 4096;
    localparam int LOMO_SYNC_STAGES = 2;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } lomo_state_e;

endpackage

// File: rtl/lomo_edge_sync.sv
// lomo_edge_sync
//   Brings one asynchronous line into the clk domain through SYNC_STAGES
//   flip-flops and produces a one-cycle pulse on each rising edge of the
//   synchronised level.
// Ports
//   clk    in   system clock
//   rst    in   asynchronous reset, active low
//   din    in   asynchronous input line
//   level  out  synchronised level (last synchroniser stage)
//   rise   out  one-cycle pulse when level goes 0 -> 1
module lomo_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/lomo_frame_receiver.sv
// lomo_frame_receiver
//   Receives the LOMO serial triple (MK frame marker, CLK bit clock, SRL data),
//   resynchronised into the clk domain. Locks on MK, shifts SRL MSB first on
//   every CLK rising edge, emits completed words tagged with their index in
//   the frame, counts good frames and keeps sticky framing-fault flags.
// Ports
//   clk        in   system clock (80 MHz)
//   rst        in   asynchronous reset, active low
//   iMK/iCLK/iSRL   in   serial triple, asynchronous to clk
//   oWord      out  last completed word
//   oIdx       out  index of oWord within the frame
//   oSof       out  high with oValid for the first word of a frame
//   oValid     out  one-cycle strobe qualifying oWord/oIdx/oSof
//   oLocked    out  receiver is locked onto a frame
//   oErrShort  out  sticky: MK before the frame was complete
//   oErrLong   out  sticky: bit received after a full frame without MK
//   oErrTout   out  sticky: bit clock lost while locked
//   iErrClr    in   synchronous pulse clearing the sticky flags
//   oFrameCnt  out  number of complete good frames (wraps)
module lomo_frame_receiver
    import lomo_pkg::*;
#(
    parameter int WORD_BITS   = LOMO_WORD_BITS,
    parameter int FRAME_WORDS = LOMO_FRAME_WORDS,
    parameter int TIMEOUT_CYC = LOMO_TIMEOUT_CYC,
    parameter int SYNC_STAGES = LOMO_SYNC_STAGES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iMK,
    input  logic                           iCLK,
    input  logic                           iSRL,
    output logic [WORD_BITS-1:0]           oWord,
    output logic [$clog2(FRAME_WORDS)-1:0] oIdx,
    output logic                           oSof,
    output logic                           oValid,
    output logic                           oLocked,
    output logic                           oErrShort,
    output logic                           oErrLong,
    output logic                           oErrTout,
    input  logic                           iErrClr,
    output logic [15:0]                    oFrameCnt
);

    localparam int IDX_W  = $clog2(FRAME_WORDS);
    // word counter must reach FRAME_WORDS itself to recognise a full frame
    localparam int WC_W   = $clog2(FRAME_WORDS + 1);
    localparam int BC_W   = $clog2(WORD_BITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC);

    localparam logic [WC_W-1:0]   WC_FULL   = WC_W'(FRAME_WORDS);
    localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(WORD_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic mk_rise, mk_level_unused;
    logic clk_rise, clk_level_unused;
    logic srl_level, srl_rise_unused;

    lomo_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mk (
        .clk(clk), .rst(rst), .din(iMK), .level(mk_level_unused), .rise(mk_rise)
    );

    lomo_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .rst(rst), .din(iCLK), .level(clk_level_unused), .rise(clk_rise)
    );

    // Same stage count as CLK, so srl_level is the bit that was stable at the CLK rise.
    lomo_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_srl (
        .clk(clk), .rst(rst), .din(iSRL), .level(srl_level), .rise(srl_rise_unused)
    );

    lomo_state_e          state_q, state_d;
    logic [WORD_BITS-1:0] sr_q, sr_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 sof_q, sof_d;
    logic                 valid_q, valid_d;
    logic                 err_short_q, err_short_d;
    logic                 err_long_q, err_long_d;
    logic                 err_tout_q, err_tout_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;

    logic                 set_short, set_long, set_tout;
    logic [BC_W-1:0]      bit_work;
    logic [WC_W-1:0]      word_work;
    logic [WORD_BITS-1:0] shifted;

    // bit_work/word_work carry the counters through a cycle in which MK is
    // handled before the coincident bit, so the bit lands in the new frame.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        idle_d      = idle_q;
        word_d      = word_q;
        idx_d       = idx_q;
        sof_d       = 1'b0;
        valid_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        set_short   = 1'b0;
        set_long    = 1'b0;
        set_tout    = 1'b0;
        bit_work    = bit_cnt_q;
        word_work   = word_cnt_q;
        shifted     = {sr_q[WORD_BITS-2:0], srl_level};

        case (state_q)
            HUNT: begin
                idle_d = '0;
                if (mk_rise) begin
                    state_d    = RECV;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (clk_rise) begin
                        sr_d      = shifted;
                        bit_cnt_d = BC_W'(1);
                    end
                end
            end

            RECV: begin
                if (mk_rise) begin
                    if (word_cnt_q == WC_FULL && bit_cnt_q == '0) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        set_short = 1'b1;
                    end
                    bit_work  = '0;
                    word_work = '0;
                end

                if (clk_rise) begin
                    if (word_work == WC_FULL) begin
                        set_long  = 1'b1;
                        state_d   = HUNT;
                        bit_work  = '0;
                        word_work = '0;
                    end else begin
                        sr_d = shifted;
                        if (bit_work == BC_LAST) begin
                            word_d    = shifted;
                            idx_d     = word_work[IDX_W-1:0];
                            sof_d     = (word_work == '0);
                            valid_d   = 1'b1;
                            bit_work  = '0;
                            word_work = word_work + WC_W'(1);
                        end else begin
                            bit_work = bit_work + BC_W'(1);
                        end
                    end
                end

                // Any activity on MK or CLK proves the link is alive.
                if (mk_rise || clk_rise) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    set_tout  = 1'b1;
                    state_d   = HUNT;
                    bit_work  = '0;
                    word_work = '0;
                    idle_d    = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end

                bit_cnt_d  = bit_work;
                word_cnt_d = word_work;
            end

            default: state_d = HUNT;
        endcase

        // A fault occurring in the same cycle as the clear request stays visible.
        err_short_d = set_short | (err_short_q & ~iErrClr);
        err_long_d  = set_long  | (err_long_q  & ~iErrClr);
        err_tout_d  = set_tout  | (err_tout_q  & ~iErrClr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            idle_q      <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            sof_q       <= 1'b0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_tout_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            idle_q      <= idle_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            sof_q       <= sof_d;
            valid_q     <= valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            err_tout_q  <= err_tout_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign oWord     = word_q;
    assign oIdx      = idx_q;
    assign oSof      = sof_q;
    assign oValid    = valid_q;
    assign oLocked   = (state_q == RECV);
    assign oErrShort = err_short_q;
    assign oErrLong  = err_long_q;
    assign oErrTout  = err_tout_q;
    assign oFrameCnt = frame_cnt_q;

endmodule

// File: tb/tb_lomo_frame_receiver.sv
`timescale 1ns/1ps
// tb_lomo_frame_receiver
//   Drives the serial triple like the LOMO imitator and compares the receiver
//   against a bit-queue model of the framing rules.
module tb_lomo_frame_receiver;
    import lomo_pkg::*;

    localparam int WB = LOMO_WORD_BITS;
    localparam int FW = LOMO_FRAME_WORDS;

    logic        clk = 1'b0;
    logic        rst;
    logic        iMK, iCLK, iSRL, iErrClr;
    logic [11:0] oWord;
    logic [4:0]  oIdx;
    logic        oSof, oValid, oLocked, oErrShort, oErrLong, oErrTout;
    logic [15:0] oFrameCnt;

    always #5 clk = ~clk;

    lomo_frame_receiver dut (
        .clk(clk), .rst(rst), .iMK(iMK), .iCLK(iCLK), .iSRL(iSRL),
        .oWord(oWord), .oIdx(oIdx), .oSof(oSof), .oValid(oValid),
        .oLocked(oLocked), .oErrShort(oErrShort), .oErrLong(oErrLong),
        .oErrTout(oErrTout), .iErrClr(iErrClr), .oFrameCnt(oFrameCnt)
    );

    int          checks = 0;
    int          errors = 0;
    logic [17:0] obsQ[$];
    logic [17:0] expQ[$];

    // Reference model state: bits of the current frame since the last MK.
    bit          curBits[$];
    bit          locked;
    logic [15:0] expFrameCnt;
    bit          expShort, expLong, expTout;

    // Collects every strobed word; a stuck oValid shows up as extra entries.
    always @(negedge clk) begin
        if (rst === 1'b1 && oValid === 1'b1) obsQ.push_back({oIdx, oSof, oWord});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic modelReset();
        curBits.delete();
        locked = 0; expFrameCnt = '0;
        expShort = 0; expLong = 0; expTout = 0;
    endtask

    task automatic modelMark();
        if (locked) begin
            if (curBits.size() == FW * WB) expFrameCnt = expFrameCnt + 16'd1;
            else expShort = 1;
        end
        locked = 1;
        curBits.delete();
    endtask

    task automatic modelBit(input bit b);
        int n;
        int idx;
        logic [WB-1:0] w;
        if (!locked) return;
        if (curBits.size() == FW * WB) begin
            expLong = 1; locked = 0; curBits.delete();
            return;
        end
        curBits.push_back(b);
        n = curBits.size();
        if (n % WB == 0) begin
            w = '0;
            for (int i = n - WB; i < n; i++) w = {w[WB-2:0], curBits[i]};
            idx = n / WB - 1;
            expQ.push_back({5'(idx), 1'(idx == 0), w});
        end
    endtask

    task automatic modelTimeout();
        if (locked) begin
            expTout = 1; locked = 0; curBits.delete();
        end
    endtask

    // One marker pulse (isMark) or one data bit with SRL noise before setup.
    task automatic applyStimulus(input bit isMark, input bit b);
        if (isMark) begin
            iMK = 1'b1; modelMark();
            waitCycles(4);
            iMK = 1'b0;
            waitCycles(3);
        end else begin
            iSRL = 1'($urandom());
            waitCycles(int'($urandom_range(2, 1)));
            iSRL = b;
            waitCycles(3);
            iCLK = 1'b1; modelBit(b);
            waitCycles(3);
            iCLK = 1'b0;
        end
    endtask

    task automatic sendWord(input logic [11:0] w);
        for (int i = WB - 1; i >= 0; i--) applyStimulus(1'b0, w[i]);
    endtask

    task automatic checkWords(input string tag);
        logic [17:0] o, e;
        waitCycles(4);
        checkOutput({tag, "_count"}, 32'(obsQ.size()), 32'(expQ.size()));
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            o = obsQ.pop_front();
            e = expQ.pop_front();
            checkOutput({tag, "_word"}, 32'(o), 32'(e));
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_locked"}, 32'(oLocked), 32'(locked));
        checkOutput({tag, "_errShort"}, 32'(oErrShort), 32'(expShort));
        checkOutput({tag, "_errLong"}, 32'(oErrLong), 32'(expLong));
        checkOutput({tag, "_errTout"}, 32'(oErrTout), 32'(expTout));
        checkOutput({tag, "_frameCnt"}, 32'(oFrameCnt), 32'(expFrameCnt));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_oWord"}, 32'(oWord), 32'd0);
        checkOutput({tag, "_oIdx"}, 32'(oIdx), 32'd0);
        checkOutput({tag, "_oSof"}, 32'(oSof), 32'd0);
        checkOutput({tag, "_oValid"}, 32'(oValid), 32'd0);
        checkOutput({tag, "_oLocked"}, 32'(oLocked), 32'd0);
        checkOutput({tag, "_oErrShort"}, 32'(oErrShort), 32'd0);
        checkOutput({tag, "_oErrLong"}, 32'(oErrLong), 32'd0);
        checkOutput({tag, "_oErrTout"}, 32'(oErrTout), 32'd0);
        checkOutput({tag, "_oFrameCnt"}, 32'(oFrameCnt), 32'd0);
    endtask

    initial begin
        rst = 1'b0; iMK = 1'b0; iCLK = 1'b0; iSRL = 1'b0; iErrClr = 1'b0;
        modelReset();
        waitCycles(3);
        #1 checkAllZero("reset");
        @(negedge clk) rst = 1'b1;
        waitCycles(5);

        // Two clean frames with word k = 0xA00 + k
        applyStimulus(1'b1, 1'b0);
        checkState("lock");
        for (int k = 0; k < FW; k++) sendWord(12'hA00 + 12'(k));
        applyStimulus(1'b1, 1'b0);
        checkWords("clean1");
        checkState("clean1");
        for (int k = 0; k < FW; k++) sendWord(12'hA00 + 12'(k));
        checkWords("clean2");
        checkState("clean2");

        // Close frame 2, then a short frame of 20 words
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 20; k++) sendWord(12'($urandom()));
        applyStimulus(1'b1, 1'b0);
        checkWords("short");
        checkState("short");
        for (int k = 0; k < 3; k++) sendWord(12'($urandom()));
        checkWords("restart");

        // Reset in the middle of a frame (7 words in)
        for (int k = 0; k < 4; k++) sendWord(12'($urandom()));
        checkWords("premid");
        @(negedge clk) rst = 1'b0;
        modelReset();
        #1 checkAllZero("midreset");
        waitCycles(3);
        rst = 1'b1;
        waitCycles(20);
        checkWords("postreset");
        checkState("postreset");

        // Full frame then one extra bit without a marker
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < FW; k++) sendWord(12'($urandom()));
        applyStimulus(1'b0, 1'($urandom()));
        checkWords("long");
        checkState("long");

        // Bit clock stops mid-word
        applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) sendWord(12'($urandom()));
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'($urandom()));
        waitCycles(4000);
        checkOutput("tout_before_locked", 32'(oLocked), 32'(locked));
        waitCycles(200);
        modelTimeout();
        checkWords("tout");
        checkState("tout");
        @(negedge clk) iErrClr = 1'b1;
        @(negedge clk) iErrClr = 1'b0;
        expShort = 0; expLong = 0; expTout = 0;
        waitCycles(1);
        checkState("errclr");

        // Randomised run of back-to-back good frames
        applyStimulus(1'b1, 1'b0);
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < FW; k++) sendWord(12'($urandom()));
            applyStimulus(1'b1, 1'b0);
            checkWords("rand");
            checkOutput("rand_frameCnt", 32'(oFrameCnt), 32'(expFrameCnt));
        end
        checkState("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
